// File: rtl/bsg_counter_dynamic_limit_step.sv
// Up-counter with runtime limit, variable step, wrap/saturate mode and wrap/saturate flags.
// Optional saturating wrap counter output enabled by defining BSG_COUNTER_DL_WRAP_COUNT_EN.
module bsg_counter_dynamic_limit_step #(
  parameter int unsigned width_p          = 16,
  parameter int unsigned step_width_p     = 4,
  parameter int unsigned wrap_cnt_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        clear_i,
  input  logic                        en_i,
  input  logic [step_width_p-1:0]     step_i,
  input  logic [width_p-1:0]          limit_i,
  input  logic                        saturate_i,
  output logic [width_p-1:0]          counter_o,
  output logic                        at_limit_o,
  output logic                        wrap_o,
`ifdef BSG_COUNTER_DL_WRAP_COUNT_EN
  output logic [wrap_cnt_width_p-1:0] wrap_count_o,
`endif
  output logic                        sat_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               wrap_q, wrap_d;
  logic               sat_q, sat_d;
  logic [width_p:0]   sum;

  // One extra bit so an all-ones count plus step cannot silently overflow.
  assign sum = {1'b0, count_q} + {{(width_p + 1 - step_width_p){1'b0}}, step_i};

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (clear_i) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (en_i) begin
      if (sum <= {1'b0, limit_i}) begin
        count_d = sum[width_p-1:0];
        sat_d   = 1'b0;
      end else if (saturate_i) begin
        count_d = limit_i;
        sat_d   = 1'b1;
      end else begin
        count_d = '0;
        wrap_d  = 1'b1;
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign counter_o  = count_q;
  assign wrap_o     = wrap_q;
  assign sat_o      = sat_q;
  assign at_limit_o = (count_q == limit_i);

`ifdef BSG_COUNTER_DL_WRAP_COUNT_EN
  logic [wrap_cnt_width_p-1:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating: sticks at all-ones rather than rolling over.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clear_i) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && (wrap_cnt_q != {wrap_cnt_width_p{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_count_o = wrap_cnt_q;
`else
  logic unused_wrap_cnt_cfg;
  assign unused_wrap_cnt_cfg = (wrap_cnt_width_p > 0);
`endif

endmodule

// File: doc/bsg_counter_dynamic_limit_step.md
Name: bsg_counter_dynamic_limit_step

Overview:
Parametrised successor to the fixed-increment dynamic-limit counter. Adds variable step, count enable, synchronous clear, a wrap/saturate mode select, a registered wrap pulse, and an at-limit flag. With en_i=1, step_i=1 and saturate_i=0 its count sequence is the classic 0..limit_i, 0.. behaviour. Used for credit/timer/round-robin index generation where the limit is runtime-programmable.

Parameters:
width_p, 16, counter and limit width in bits (>=1)
step_width_p, 4, width of step_i (>=1, <=width_p)
wrap_cnt_width_p, 8, width of wrap_count_o (used only with the optional feature)

Ports:
clk_i  input  1  clock, all state on rising edge
reset_n_i  input  1  asynchronous active-low reset
clear_i  input  1  synchronous clear to 0, highest priority after reset
en_i  input  1  count enable for this cycle
step_i  input  step_width_p  increment amount, unsigned
limit_i  input  width_p  inclusive upper bound, sampled every cycle (dynamic)
saturate_i  input  1  0 = wrap mode, 1 = saturate mode
counter_o  output  width_p  registered count value
at_limit_o  output  1  combinational: counter_o == limit_i
wrap_o  output  1  registered one-cycle pulse: counter wrapped on the previous edge
sat_o  output  1  registered level: counter is being held at limit in saturate mode

Behaviour:
- Reset (reset_n_i=0, asynchronous assert, synchronous-safe deassert): counter_o=0, wrap_o=0, sat_o=0. Outputs are valid immediately on assertion, without a clock edge.
- Per-edge priority: clear_i > en_i > hold.
- clear_i=1: counter_o<=0, wrap_o<=0, sat_o<=0. This applies regardless of en_i.
- en_i=0 (no clear): counter_o holds; wrap_o<=0; sat_o holds.
- en_i=1: sum = counter_o + step_i, computed in width_p+1 bits, so there is no silent modular overflow.
  - sum <= limit_i: counter_o<=sum[width_p-1:0], wrap_o<=0, sat_o<=0.
  - sum > limit_i, saturate_i=0: counter_o<=0, wrap_o<=1, sat_o<=0. No remainder carry-over; wrap always returns to 0.
  - sum > limit_i, saturate_i=1: counter_o<=limit_i, wrap_o<=0, sat_o<=1.
- step_i=0 with en_i=1: sum equals counter_o. The counter holds unless counter_o > limit_i; see the dynamic-limit rule below.
- Dynamic limit lowered below the current count (counter_o > limit_i): the next enabled edge takes the sum>limit path. Wrap mode gives 0 plus wrap_o; saturate mode clamps to the new limit_i.
- limit_i=0: in wrap mode with step>=1, counter_o stays at 0 and wrap_o=1 on every enabled edge.
- limit_i = all-ones with counter_o = all-ones, step 1: sum = 2^width_p > limit, so the counter wraps to 0 correctly through the extra sum bit.
- Switching saturate_i mid-count takes effect on the next enabled edge. No other state depends on the mode.
- Latency: counter_o and wrap_o/sat_o update 1 cycle after the qualifying edge. at_limit_o has zero latency.
- The block has no internal FSM beyond the count register. The wrap_o and sat_o flags are pure registered functions of the edge decision.

Optional Feature:
Macro BSG_COUNTER_DL_WRAP_COUNT_EN.
- Defined: adds output wrap_count_o[wrap_cnt_width_p-1:0], registered. It is 0 on reset and on clear_i, and increments by 1 on every edge where wrap_o is set. It is saturating: it holds at all-ones and never rolls over.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
1. Reset: drive reset_n_i=0 mid-count at counter_o=5, with no clock edge -> counter_o=0, wrap_o=0 immediately. After release with en_i=1, step_i=1, limit_i=3 -> sequence 0,1,2,3,0,1, with wrap_o=1 in the cycle counter_o shows 0 after 3.
2. Step overshoot, wrap mode: limit_i=10, step_i=4, en_i=1 -> counter_o 0,4,8,0 (wrap_o pulses once), 4. at_limit_o is never 1.
3. Saturate mode: limit_i=10, step_i=4, saturate_i=1 -> counter_o 0,4,8,10,10, with sat_o=1 from the first 10. at_limit_o=1 at 10. Set saturate_i=0 -> next edge counter_o=0 and wrap_o=1.
4. Dynamic limit drop: count to 9 with limit 12, then set limit_i=5 -> next enabled edge gives counter_o=0 and wrap_o=1. Repeat in saturate mode -> counter_o=5.
5. Priority and holds: en_i=0 for 3 cycles at counter_o=7 -> holds 7 with wrap_o=0. Then clear_i=1 with en_i=1 -> counter_o=0. step_i=0, en_i=1 -> holds.
6. Width boundary (width_p=16): limit_i=16'hFFFF, preload via counting at step 15 to 16'hFFFF -> next edge with step 1 gives 0 and wrap_o=1. With BSG_COUNTER_DL_WRAP_COUNT_EN and wrap_cnt_width_p=2, 5 wraps -> wrap_count_o=3 (saturated), and clear_i resets it to 0.
